// File: rtl/nes_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : nes_mem_responder
//  Brief    : 6502 CPU bus memory responder. Decodes RAM / IO / SRAM / ROM,
//             returns registered read data and inserts rdy wait states on
//             ROM reads. Includes a ROM loader port for preload.
//             Optional SRAM at $6000-$7FFF is built only when the macro
//             NES_MEM_SRAM_EN is defined; otherwise that range is unmapped.
//  Revision : 1.0 - initial release
// ============================================================================
module nes_mem_responder #(
    parameter int ROM_WAIT = 0
) (
    input  logic        clk,
    input  logic        b_rst,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    input  logic        ren,
    input  logic        wen,
    output logic [7:0]  cpu_data_in,
    output logic        rdy,
    input  logic        ld_en,
    input  logic [14:0] ld_addr,
    input  logic [7:0]  ld_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    // Counter preset: the WAIT state lasts ROM_WAIT cycles, counting down to 0.
    localparam logic [2:0] WAIT_INIT = (ROM_WAIT > 0) ? 3'(ROM_WAIT - 1) : 3'd0;
    localparam logic       ROM_STALL = (ROM_WAIT > 0);

    state_t      state;
    state_t      next_state;
    logic [2:0]  wcnt;
    logic [14:0] raddr;

    logic        accept;
    logic        do_write;
    logic        do_read;
    logic        rom_start;
    logic        ld_write;
    logic        is_ram;
    logic        is_io;
    logic        is_sram;
    logic        is_rom;
    logic [7:0]  rd_byte;

    logic [7:0]  ram [0:2047];
    logic [7:0]  io_regs [0:7];
    logic [7:0]  rom [0:32767];

`ifdef NES_MEM_SRAM_EN
    logic [7:0]  sram [0:8191];
`endif

    // rdy comes straight from the state register, never from inputs.
    assign rdy = (state == S_IDLE);

    // Address decode and request qualification.
    always_comb begin
        is_ram    = (cpu_addr_out[15:13] == 3'b000);
        is_io     = (cpu_addr_out[15:13] == 3'b001);
`ifdef NES_MEM_SRAM_EN
        is_sram   = (cpu_addr_out[15:13] == 3'b011);
`else
        is_sram   = 1'b0;
`endif
        is_rom    = cpu_addr_out[15];
        accept    = (state == S_IDLE) && !ld_en && (ren || wen);
        do_write  = accept && wen;
        do_read   = accept && ren && !wen;
        rom_start = do_read && is_rom && ROM_STALL;
        // Loader writes are held off while a ROM read is in flight.
        ld_write  = ld_en && (state != S_WAIT);
    end

    // Read data mux; unmapped space returns the current bus value.
    always_comb begin
        rd_byte = cpu_data_in;
        if (is_ram) begin
            rd_byte = ram[cpu_addr_out[10:0]];
        end else if (is_io) begin
            rd_byte = io_regs[cpu_addr_out[2:0]];
        end else if (is_rom) begin
            rd_byte = rom[cpu_addr_out[14:0]];
`ifdef NES_MEM_SRAM_EN
        end else if (is_sram) begin
            rd_byte = sram[cpu_addr_out[12:0]];
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (ld_en) begin
                    next_state = S_LOAD;
                end else if (rom_start) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt == 3'd0) begin
                    next_state = S_IDLE;
                end
            end
            S_LOAD: begin
                if (!ld_en) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (b_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Wait counter, latched ROM address and returned read data.
    always_ff @(posedge clk) begin
        if (b_rst) begin
            wcnt        <= 3'd0;
            raddr       <= 15'd0;
            cpu_data_in <= 8'h00;
        end else begin
            if (rom_start) begin
                wcnt  <= WAIT_INIT;
                raddr <= cpu_addr_out[14:0];
            end else if ((state == S_WAIT) && (wcnt != 3'd0)) begin
                wcnt <= wcnt - 3'd1;
            end

            if ((state == S_WAIT) && (wcnt == 3'd0)) begin
                cpu_data_in <= rom[raddr];
            end else if (do_read && !rom_start) begin
                cpu_data_in <= rd_byte;
            end
        end
    end

    // IO register file; the only storage that is cleared by reset.
    always_ff @(posedge clk) begin
        if (b_rst) begin
            for (int i = 0; i < 8; i++) begin
                io_regs[i] <= 8'h00;
            end
        end else if (do_write && is_io) begin
            io_regs[cpu_addr_out[2:0]] <= cpu_data_out;
        end
    end

    // Internal RAM writes (2 KB, mirrored across $0000-$1FFF).
    always_ff @(posedge clk) begin
        if (do_write && is_ram) begin
            ram[cpu_addr_out[10:0]] <= cpu_data_out;
        end
    end

    // ROM is writable only through the loader port.
    always_ff @(posedge clk) begin
        if (ld_write) begin
            rom[ld_addr] <= ld_data;
        end
    end

`ifdef NES_MEM_SRAM_EN
    // Cartridge SRAM writes.
    always_ff @(posedge clk) begin
        if (do_write && is_sram) begin
            sram[cpu_addr_out[12:0]] <= cpu_data_out;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_nes_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nes_mem_responder
//  Brief    : Directed self-checking bench for nes_mem_responder, ROM_WAIT=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nes_mem_responder;

    logic        clk = 1'b0;
    logic        b_rst;
    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic        ren;
    logic        wen;
    logic [7:0]  cpu_data_in;
    logic        rdy;
    logic        ld_en;
    logic [14:0] ld_addr;
    logic [7:0]  ld_data;

    int checks = 0;
    int errors = 0;

    nes_mem_responder #(.ROM_WAIT(2)) dut (
        .clk          (clk),
        .b_rst        (b_rst),
        .cpu_addr_out (cpu_addr_out),
        .cpu_data_out (cpu_data_out),
        .ren          (ren),
        .wen          (wen),
        .cpu_data_in  (cpu_data_in),
        .rdy          (rdy),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr_out = a;
        cpu_data_out = d;
        wen = 1'b1;
        step();
        wen = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        cpu_addr_out = a;
        ren = 1'b1;
        step();
        ren = 1'b0;
    endtask

    task automatic test_reset();
        b_rst = 1'b1; ren = 1'b0; wen = 1'b0; ld_en = 1'b0;
        cpu_addr_out = 16'h0000; cpu_data_out = 8'h00;
        ld_addr = 15'h0000; ld_data = 8'h00;
        step(); step();
        b_rst = 1'b0;
        step();
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
        checks++;
        if (cpu_data_in !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", cpu_data_in); end
    endtask

    task automatic test_ram_mirror();
        cpu_write(16'h0003, 8'h5A);
        cpu_read(16'h1803);
        checks++;
        if (cpu_data_in !== 8'h5A) begin errors++; $display("FAIL ram_mirror: got %h expected 5a", cpu_data_in); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL ram_rdy: got %b expected 1", rdy); end
    endtask

    task automatic test_io_regs();
        cpu_write(16'h2001, 8'h77);
        cpu_read(16'h3FF9);
        checks++;
        if (cpu_data_in !== 8'h77) begin errors++; $display("FAIL io_mirror: got %h expected 77", cpu_data_in); end
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        cpu_read(16'h2001);
        checks++;
        if (cpu_data_in !== 8'h00) begin errors++; $display("FAIL io_reset: got %h expected 00", cpu_data_in); end
    endtask

    task automatic test_rom_load_wait();
        ld_en = 1'b1; ld_addr = 15'h7FFC; ld_data = 8'h34;
        step();
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL load_rdy: got %b expected 0", rdy); end
        step();
        ld_addr = 15'h1000; ld_data = 8'hE1;
        step(); step();
        ld_en = 1'b0;
        step();
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL load_exit_rdy: got %b expected 1", rdy); end
        // ROM read, CPU holds request while stalled.
        cpu_addr_out = 16'hFFFC;
        ren = 1'b1;
        step();
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL wait1_rdy: got %b expected 0", rdy); end
        step();
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL wait2_rdy: got %b expected 0", rdy); end
        checks++;
        if (cpu_data_in !== 8'h00) begin errors++; $display("FAIL wait_data_hold: got %h expected 00", cpu_data_in); end
        step();
        ren = 1'b0;
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL wait_done_rdy: got %b expected 1", rdy); end
        checks++;
        if (cpu_data_in !== 8'h34) begin errors++; $display("FAIL rom_data: got %h expected 34", cpu_data_in); end
    endtask

    task automatic test_open_bus_rom_write();
        cpu_write(16'h1234, 8'hAB);
        cpu_read(16'h1234);
        checks++;
        if (cpu_data_in !== 8'hAB) begin errors++; $display("FAIL ram_read: got %h expected ab", cpu_data_in); end
        cpu_read(16'h4020);
        checks++;
        if (cpu_data_in !== 8'hAB) begin errors++; $display("FAIL open_bus: got %h expected ab", cpu_data_in); end
        cpu_write(16'h9000, 8'h55);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL rom_write_rdy: got %b expected 1", rdy); end
        cpu_addr_out = 16'h9000;
        ren = 1'b1;
        step(); step(); step();
        ren = 1'b0;
        checks++;
        if (cpu_data_in !== 8'hE1) begin errors++; $display("FAIL rom_write_drop: got %h expected e1", cpu_data_in); end
    endtask

    task automatic test_read_write_both();
        cpu_addr_out = 16'h0010; cpu_data_out = 8'hC3;
        ren = 1'b1; wen = 1'b1;
        step();
        ren = 1'b0; wen = 1'b0;
        checks++;
        if (cpu_data_in !== 8'hE1) begin errors++; $display("FAIL both_hold: got %h expected e1", cpu_data_in); end
        cpu_read(16'h0010);
        checks++;
        if (cpu_data_in !== 8'hC3) begin errors++; $display("FAIL both_write: got %h expected c3", cpu_data_in); end
    endtask

    task automatic test_reset_during_wait();
        cpu_addr_out = 16'h8000;
        ren = 1'b1;
        step();
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL rst_wait_enter: got %b expected 0", rdy); end
        ren = 1'b0;
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL rst_wait_rdy: got %b expected 1", rdy); end
        checks++;
        if (cpu_data_in !== 8'h00) begin errors++; $display("FAIL rst_wait_data: got %h expected 00", cpu_data_in); end
        step(); step();
        checks++;
        if (cpu_data_in !== 8'h00) begin errors++; $display("FAIL rst_wait_no_return: got %h expected 00", cpu_data_in); end
    endtask

    task automatic test_back_to_back();
        cpu_write(16'h0100, 8'h11);
        cpu_write(16'h0101, 8'h22);
        cpu_addr_out = 16'h0100;
        ren = 1'b1;
        step();
        checks++;
        if (cpu_data_in !== 8'h11) begin errors++; $display("FAIL b2b_first: got %h expected 11", cpu_data_in); end
        cpu_addr_out = 16'h0101;
        step();
        ren = 1'b0;
        checks++;
        if (cpu_data_in !== 8'h22) begin errors++; $display("FAIL b2b_second: got %h expected 22", cpu_data_in); end
    endtask

    task automatic test_sram();
        logic [7:0] exp;
`ifdef NES_MEM_SRAM_EN
        exp = 8'h99;
`else
        exp = 8'h22;
`endif
        cpu_write(16'h6000, 8'h99);
        cpu_read(16'h6000);
        checks++;
        if (cpu_data_in !== exp) begin errors++; $display("FAIL sram_read: got %h expected %h", cpu_data_in, exp); end
    endtask

    initial begin
        test_reset();
        test_ram_mirror();
        test_io_regs();
        test_rom_load_wait();
        test_open_bus_rom_write();
        test_read_write_both();
        test_reset_during_wait();
        test_back_to_back();
        test_sram();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
